// File: rtl/dff_deserializer_for_cb_pkg.sv
// Shared constants and types for the column-buffer deserializer.
`include "dff_deserializer_for_cb_defs.sv"

package dff_deserializer_for_cb_pkg;
   localparam int SEG_DEPTH = `CB_SEG_DEPTH;
   localparam int CNT_WIDTH = `CB_CNT_WIDTH;
   localparam int STG_DEPTH = SEG_DEPTH - 1;

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t LAST_CNT = cnt_t'(SEG_DEPTH - 1);
endpackage

// File: rtl/dff_deserializer_for_cb_if.sv
// Serial word input and parallel frame output bundle of the deserializer.
interface dff_deserializer_for_cb_if #(
   parameter int DATA_WIDTH = 32
);
   import dff_deserializer_for_cb_pkg::*;

   logic                  hold;
   logic                  sync;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] D;
   logic [DATA_WIDTH-1:0] Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8;
   logic                  valid_out;
   cnt_t                  frame_cnt;

   modport master (
      output hold, sync, valid_in, D,
      input  Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, valid_out, frame_cnt
   );

   modport slave (
      input  hold, sync, valid_in, D,
      output Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, valid_out, frame_cnt
   );
endinterface

// File: rtl/dff_deserializer_for_cb_defs.sv
// Frame geometry shared with the serializer segment so both ends agree on frame size.
`ifndef CB_SEG_DEFS_SV
`define CB_SEG_DEFS_SV
`define CB_SEG_DEPTH 8
`define CB_CNT_WIDTH 3
`endif

// File: rtl/dff_deserializer_for_cb_dff.sv
// Word register with synchronous active-high reset and load enable; 1-cycle latency.
module dff_hold_sync_high_reset #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);
   logic [DATA_WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/dff_deserializer_for_cb.sv
// Collects 8 serial words into Q1..Q8 with a one-cycle valid pulse; outputs update on the 8th accept edge.
// No backpressure: hold freezes everything, sync restarts the frame.
module dff_deserializer_for_cb
   import dff_deserializer_for_cb_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   dff_deserializer_for_cb_if.slave  bus
);
   logic                  accept;
   logic                  complete;
   logic [DATA_WIDTH-1:0] stg_q [STG_DEPTH];
   logic [DATA_WIDTH-1:0] stg_d [STG_DEPTH];
   logic [DATA_WIDTH-1:0] out_q [SEG_DEPTH];
   logic [DATA_WIDTH-1:0] out_d [SEG_DEPTH];
   cnt_t                  frame_cnt_q, frame_cnt_d;
   logic                  valid_out_q, valid_out_d;

   assign accept   = bus.valid_in & ~bus.hold;
   // A sync word always starts a fresh frame, so it can never complete the old one.
   assign complete = accept & ~bus.sync & (frame_cnt_q == LAST_CNT);

   genvar i;
   generate
      for (i = 0; i < STG_DEPTH; i++) begin : g_stg
         if (i == STG_DEPTH - 1) begin : g_tail
            assign stg_d[i] = bus.D;
         end else begin : g_chain
            assign stg_d[i] = stg_q[i+1];
         end

         dff_hold_sync_high_reset #(.DATA_WIDTH(DATA_WIDTH)) u_stg (
            .clk  (clk),
            .rst  (rst),
            .en_i (accept),
            .d_i  (stg_d[i]),
            .q_o  (stg_q[i])
         );
      end

      for (i = 0; i < SEG_DEPTH; i++) begin : g_out
         if (i == SEG_DEPTH - 1) begin : g_last
            assign out_d[i] = bus.D;
         end else begin : g_stage
            assign out_d[i] = stg_q[i];
         end

         dff_hold_sync_high_reset #(.DATA_WIDTH(DATA_WIDTH)) u_out (
            .clk  (clk),
            .rst  (rst),
            .en_i (complete),
            .d_i  (out_d[i]),
            .q_o  (out_q[i])
         );
      end
   endgenerate

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      valid_out_d = valid_out_q;
      if (!bus.hold) begin
         valid_out_d = complete;
         if (bus.sync) begin
            frame_cnt_d = bus.valid_in ? cnt_t'(1) : cnt_t'(0);
         end else if (bus.valid_in) begin
            frame_cnt_d = frame_cnt_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         valid_out_q <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign bus.Q1        = out_q[0];
   assign bus.Q2        = out_q[1];
   assign bus.Q3        = out_q[2];
   assign bus.Q4        = out_q[3];
   assign bus.Q5        = out_q[4];
   assign bus.Q6        = out_q[5];
   assign bus.Q7        = out_q[6];
   assign bus.Q8        = out_q[7];
   assign bus.valid_out = valid_out_q;
   assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_dff_deserializer_for_cb.sv
// Directed plus random stimulus against a queue-based frame model.
module tb_dff_deserializer_for_cb;
   logic clk;
   logic rst;

   dff_deserializer_for_cb_if #(.DATA_WIDTH(32)) bus ();

   dff_deserializer_for_cb #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   logic [31:0] part [$];
   logic [31:0] exp_q [8];
   logic        exp_vld;
   int          pulses;

   function automatic logic [31:0] get_q(int idx);
      case (idx)
         0: return bus.Q1;
         1: return bus.Q2;
         2: return bus.Q3;
         3: return bus.Q4;
         4: return bus.Q5;
         5: return bus.Q6;
         6: return bus.Q7;
         default: return bus.Q8;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model: a frame is whatever has been accepted since the last completion/sync/reset.
   task automatic cyc(input logic r, input logic h, input logic s, input logic v, input logic [31:0] d);
      rst = r; bus.hold = h; bus.sync = s; bus.valid_in = v; bus.D = d;
      if (r) begin
         part.delete();
         foreach (exp_q[k]) exp_q[k] = '0;
         exp_vld = 1'b0;
      end else if (!h) begin
         exp_vld = 1'b0;
         if (s) begin
            part.delete();
            if (v) part.push_back(d);
         end else if (v) begin
            part.push_back(d);
            if (part.size() == 8) begin
               foreach (exp_q[k]) exp_q[k] = part[k];
               part.delete();
               exp_vld = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (exp_vld && !h) pulses++;
      chk("valid_out", {31'b0, bus.valid_out}, {31'b0, exp_vld});
      chk("frame_cnt", {29'b0, bus.frame_cnt}, 32'(part.size()));
      for (int k = 0; k < 8; k++) chk($sformatf("Q%0d", k + 1), get_q(k), exp_q[k]);
   endtask

   task automatic acc(input logic [31:0] d);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
   endtask

   initial begin
      int w;
      int c;
      logic v;
      foreach (exp_q[k]) exp_q[k] = '0;
      exp_vld = 1'b0;
      pulses  = 0;

      // Reset, then a frame of 0x11..0x88
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD);
      for (int k = 1; k <= 8; k++) acc(32'(k * 'h11));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Back-to-back frames
      pulses = 0;
      for (int k = 1; k <= 16; k++) acc(32'(k));
      chk("b2b_pulses", 32'(pulses), 32'd2);

      // Hold in the middle of a frame
      for (int k = 0; k < 5; k++) acc(32'hA0 + 32'(k));
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hFF);
      for (int k = 5; k < 8; k++) acc(32'hA0 + 32'(k));
      // Hold stretches the pulse
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hFF);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hFF);

      // Sync discards a partial frame, including at count 7
      for (int k = 0; k < 6; k++) acc(32'hB0 + 32'(k));
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hC0);
      for (int k = 1; k < 8; k++) acc(32'hC0 + 32'(k));
      for (int k = 0; k < 7; k++) acc(32'hE0 + 32'(k));
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hE7);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Reset mid-frame
      for (int k = 1; k <= 8; k++) acc(32'(k * 'h11));
      for (int k = 0; k < 4; k++) acc(32'h50 + 32'(k));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h77);
      for (int k = 0; k < 8; k++) acc(32'hD0 + 32'(k));

      // Eight words spread over 20 cycles
      pulses = 0;
      w = 8;
      for (c = 20; c > 0; c--) begin
         v = (w == c) ? 1'b1 : (w > 0 && $urandom_range(1) == 1);
         cyc(1'b0, 1'b0, 1'b0, v, v ? (32'h60 + 32'(8 - w)) : 32'hBAD);
         if (v) w--;
      end
      chk("gap_pulses", 32'(pulses), 32'd1);

      // Random mix of all controls
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(15) == 0,
             $urandom_range(3) != 0, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
